// File: rtl/cmos_cap_pkg.sv
// -----------------------------------------------------------------------------
// cmos_cap_pkg
// Shared types and constants for the OV5640 capture front end.
//   cap_state_e   : capture state machine encoding (S_SKIP, S_WAIT, S_ACTIVE)
//   COORD_W       : width of the pixel x/y coordinates
//   PIX_W         : width of a packed RGB565 pixel
//   RGB_*         : RGB565 field positions inside a packed pixel
//   coord_sat_inc : coordinate increment that saturates at all-ones
// -----------------------------------------------------------------------------
package cmos_cap_pkg;

  typedef enum logic [1:0] {
    S_SKIP   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACTIVE = 2'd2
  } cap_state_e;

  localparam int COORD_W = 12;
  localparam int PIX_W   = 16;

  localparam logic [COORD_W-1:0] COORD_MAX = {COORD_W{1'b1}};

  // RGB565: red in the first (high) byte, blue in the low bits of the second.
  localparam int RGB_R_MSB = 15;
  localparam int RGB_R_LSB = 11;
  localparam int RGB_G_MSB = 10;
  localparam int RGB_G_LSB = 5;
  localparam int RGB_B_MSB = 4;
  localparam int RGB_B_LSB = 0;

  function automatic logic [COORD_W-1:0] coord_sat_inc(input logic [COORD_W-1:0] v);
    if (v == COORD_MAX) begin
      return COORD_MAX;
    end else begin
      return v + 12'd1;
    end
  endfunction

endpackage

// File: rtl/cmos_byte_pack.sv
// -----------------------------------------------------------------------------
// cmos_byte_pack
// Registers the sensor bus once, detects the normalised vsync rising edge and
// href falling edge, and pairs consecutive href bytes into 16-bit words.
// Ports:
//   clk, rst_n     : pixel clock, async active-low reset
//   pack_en_i      : byte pairing enabled (capture state machine is active)
//   cmos_vsync_i   : raw sensor vsync
//   cmos_href_i    : raw sensor line-valid
//   cmos_db_i      : raw sensor data byte
//   vs_edge_o      : frame boundary (registered vsync rising, polarity fixed)
//   href_o         : registered href
//   href_fall_o    : registered href falling edge
//   odd_drop_o     : line ended with an unpaired byte
//   word_stb_o     : word_o holds a complete pixel this cycle
//   word_o         : {first byte, second byte}
// -----------------------------------------------------------------------------
module cmos_byte_pack
  import cmos_cap_pkg::*;
#(
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pack_en_i,
  input  logic             cmos_vsync_i,
  input  logic             cmos_href_i,
  input  logic [7:0]       cmos_db_i,
  output logic             vs_edge_o,
  output logic             href_o,
  output logic             href_fall_o,
  output logic             odd_drop_o,
  output logic             word_stb_o,
  output logic [PIX_W-1:0] word_o
);

  logic       vs_q;
  logic       vs_prev_q;
  logic       href_q;
  logic       href_prev_q;
  logic [7:0] db_q;
  logic [7:0] hi_q;
  logic [7:0] hi_d;
  logic       phase_q;
  logic       phase_d;
  logic       vs_edge_s;

  assign vs_edge_s = vs_q & ~vs_prev_q;

  // Pairing control: a frame boundary or a gap in href restarts on a high byte.
  always_comb begin
    phase_d = 1'b0;
    hi_d    = hi_q;
    if (pack_en_i && !vs_edge_s && href_q) begin
      phase_d = ~phase_q;
      if (!phase_q) begin
        hi_d = db_q;
      end else begin
        hi_d = hi_q;
      end
    end else begin
      phase_d = 1'b0;
    end
  end

  // Input registers, edge-detect history and pairing state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q        <= 1'b0;
      vs_prev_q   <= 1'b0;
      href_q      <= 1'b0;
      href_prev_q <= 1'b0;
      db_q        <= 8'd0;
      hi_q        <= 8'd0;
      phase_q     <= 1'b0;
    end else begin
      // Normalised so that the active vsync level is always 1.
      vs_q        <= cmos_vsync_i ^ ~VSYNC_POL;
      vs_prev_q   <= vs_q;
      href_q      <= cmos_href_i;
      href_prev_q <= href_q;
      db_q        <= cmos_db_i;
      hi_q        <= hi_d;
      phase_q     <= phase_d;
    end
  end

  assign vs_edge_o   = vs_edge_s;
  assign href_o      = href_q;
  assign href_fall_o = href_prev_q & ~href_q;
  assign odd_drop_o  = pack_en_i & ~href_q & phase_q;
  // A frame boundary wins over a pixel completing in the same cycle.
  assign word_stb_o  = pack_en_i & ~vs_edge_s & href_q & phase_q;
  assign word_o      = {hi_q, db_q};

endmodule

// File: rtl/cmos_capture.sv
// -----------------------------------------------------------------------------
// cmos_capture
// OV5640 parallel-bus capture stage in the pixel-clock domain. Skips the first
// SKIP_FRAMES frames after reset or enable, emits RGB565 pixels tagged with
// x/y and start-of-frame, and reports per-frame geometry errors.
// Optional feature (macro CAPTURE_CROP_EN): only pixels inside the CROP_*
// window are emitted, with window-relative coordinates. Without the macro
// every pixel is emitted and CROP_* have no effect.
// Ports:
//   clk, rst_n        : pixel clock, async active-low reset
//   capture_en        : level enable; a rising edge restarts frame skipping
//   cmos_vsync/href/db: sensor bus
//   pix_valid         : one-cycle pixel strobe
//   pix_data          : RGB565, first byte in [15:8]
//   pix_x, pix_y      : pixel coordinates
//   sof               : first pixel of a frame
//   frame_done        : one-cycle pulse at the end of a captured frame
//   size_err          : geometry result of the last frame, valid with frame_done
//   frame_cnt         : captured frames, wraps
//   busy              : capture state machine is in S_ACTIVE
// -----------------------------------------------------------------------------
module cmos_capture
  import cmos_cap_pkg::*;
#(
  parameter int SKIP_FRAMES = 4,
  parameter int H_ACTIVE    = 800,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_POL   = 1,
  parameter int CROP_X0     = 0,
  parameter int CROP_Y0     = 0,
  parameter int CROP_W      = 800,
  parameter int CROP_H      = 480
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               capture_en,
  input  logic               cmos_vsync,
  input  logic               cmos_href,
  input  logic [7:0]         cmos_db,
  output logic               pix_valid,
  output logic [PIX_W-1:0]   pix_data,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               sof,
  output logic               frame_done,
  output logic               size_err,
  output logic [15:0]        frame_cnt,
  output logic               busy
);

  localparam logic [15:0]        SKIP_N = 16'(SKIP_FRAMES);
  localparam logic [COORD_W-1:0] H_N    = 12'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_N    = 12'(V_ACTIVE);

  cap_state_e         state_q;
  cap_state_e         state_d;
  logic [15:0]        skip_cnt_q;
  logic               en_prev_q;
  logic               restart_q;
  logic [COORD_W-1:0] x_q;
  logic [COORD_W-1:0] y_q;
  logic               err_q;
  logic               first_q;

  logic               pix_valid_q;
  logic [PIX_W-1:0]   pix_data_q;
  logic [COORD_W-1:0] pix_x_q;
  logic [COORD_W-1:0] pix_y_q;
  logic               sof_q;
  logic               frame_done_q;
  logic               size_err_q;
  logic [15:0]        frame_cnt_q;
  logic               busy_q;

  logic               vs_edge_s;
  logic               href_s;
  logic               href_fall_s;
  logic               odd_drop_s;
  logic               word_stb_s;
  logic [PIX_W-1:0]   word_s;
  logic               en_rise_s;
  logic               win_s;
  logic [COORD_W-1:0] rel_x_s;
  logic [COORD_W-1:0] rel_y_s;

  cmos_byte_pack #(
    .VSYNC_POL (VSYNC_POL != 0)
  ) u_byte_pack (
    .clk          (clk),
    .rst_n        (rst_n),
    .pack_en_i    (state_q == S_ACTIVE),
    .cmos_vsync_i (cmos_vsync),
    .cmos_href_i  (cmos_href),
    .cmos_db_i    (cmos_db),
    .vs_edge_o    (vs_edge_s),
    .href_o       (href_s),
    .href_fall_o  (href_fall_s),
    .odd_drop_o   (odd_drop_s),
    .word_stb_o   (word_stb_s),
    .word_o       (word_s)
  );

  assign en_rise_s = capture_en & ~en_prev_q;

`ifdef CAPTURE_CROP_EN
  localparam logic [COORD_W-1:0] CX0 = 12'(CROP_X0);
  localparam logic [COORD_W-1:0] CX1 = 12'(CROP_X0 + CROP_W);
  localparam logic [COORD_W-1:0] CY0 = 12'(CROP_Y0);
  localparam logic [COORD_W-1:0] CY1 = 12'(CROP_Y0 + CROP_H);

  assign win_s   = (x_q >= CX0) && (x_q < CX1) && (y_q >= CY0) && (y_q < CY1);
  assign rel_x_s = x_q - CX0;
  assign rel_y_s = y_q - CY0;
`else
  // The window degenerates to always-open; CROP_* are only referenced here.
  localparam bit WIN_OPEN = (CROP_X0 >= 0) || (CROP_Y0 >= 0) ||
                            (CROP_W >= 0) || (CROP_H >= 0) || 1'b1;

  assign win_s   = WIN_OPEN;
  assign rel_x_s = x_q;
  assign rel_y_s = y_q;
`endif

  // Next-state selection for the skip / wait / active sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SKIP: begin
        if (en_rise_s) begin
          state_d = S_SKIP;
        end else if (SKIP_N == 16'd0) begin
          state_d = S_WAIT;
        end else if (vs_edge_s && ((skip_cnt_q + 16'd1) >= SKIP_N)) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_SKIP;
        end
      end
      S_WAIT: begin
        if (en_rise_s) begin
          state_d = S_SKIP;
        end else if (vs_edge_s && capture_en) begin
          state_d = S_ACTIVE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_ACTIVE: begin
        // A frame in progress always completes; the decision is made at its end.
        if (vs_edge_s) begin
          if (restart_q || en_rise_s) begin
            state_d = S_SKIP;
          end else if (capture_en) begin
            state_d = S_ACTIVE;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_ACTIVE;
        end
      end
      default: begin
        state_d = S_SKIP;
      end
    endcase
  end

  // State, counters, geometry tracking and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_SKIP;
      skip_cnt_q   <= 16'd0;
      en_prev_q    <= 1'b0;
      restart_q    <= 1'b0;
      x_q          <= 12'd0;
      y_q          <= 12'd0;
      err_q        <= 1'b0;
      first_q      <= 1'b0;
      pix_valid_q  <= 1'b0;
      pix_data_q   <= 16'd0;
      pix_x_q      <= 12'd0;
      pix_y_q      <= 12'd0;
      sof_q        <= 1'b0;
      frame_done_q <= 1'b0;
      size_err_q   <= 1'b0;
      frame_cnt_q  <= 16'd0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= (state_d == S_ACTIVE);
      en_prev_q    <= capture_en;
      pix_valid_q  <= 1'b0;
      sof_q        <= 1'b0;
      frame_done_q <= 1'b0;

      if ((state_q != S_SKIP) || en_rise_s) begin
        skip_cnt_q <= 16'd0;
      end else if (vs_edge_s) begin
        skip_cnt_q <= skip_cnt_q + 16'd1;
      end

      // Enable toggled off and back on inside a frame: re-skip after it ends.
      if (state_q != S_ACTIVE) begin
        restart_q <= 1'b0;
      end else if (en_rise_s) begin
        restart_q <= 1'b1;
      end

      if (state_q == S_ACTIVE) begin
        if (vs_edge_s) begin
          frame_done_q <= 1'b1;
          frame_cnt_q  <= frame_cnt_q + 16'd1;
          // Any line still open or not yet closed at the boundary is a short frame.
          size_err_q   <= err_q | (y_q != V_N) | (x_q != 12'd0) | href_s;
          x_q          <= 12'd0;
          y_q          <= 12'd0;
          err_q        <= 1'b0;
          first_q      <= 1'b1;
        end else begin
          if (word_stb_s) begin
            x_q         <= coord_sat_inc(x_q);
            pix_valid_q <= win_s;
            pix_data_q  <= {word_s[RGB_R_MSB:RGB_R_LSB],
                            word_s[RGB_G_MSB:RGB_G_LSB],
                            word_s[RGB_B_MSB:RGB_B_LSB]};
            pix_x_q     <= rel_x_s;
            pix_y_q     <= rel_y_s;
            sof_q       <= win_s & first_q;
            if (win_s) begin
              first_q <= 1'b0;
            end
          end else if (href_fall_s) begin
            if (x_q != H_N) begin
              err_q <= 1'b1;
            end
            x_q <= 12'd0;
            y_q <= coord_sat_inc(y_q);
          end
          if (odd_drop_s) begin
            err_q <= 1'b1;
          end
        end
      end else if (state_d == S_ACTIVE) begin
        x_q     <= 12'd0;
        y_q     <= 12'd0;
        err_q   <= 1'b0;
        first_q <= 1'b1;
      end
    end
  end

  assign pix_valid  = pix_valid_q;
  assign pix_data   = pix_data_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign sof        = sof_q;
  assign frame_done = frame_done_q;
  assign size_err   = size_err_q;
  assign frame_cnt  = frame_cnt_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_cmos_capture.sv
// -----------------------------------------------------------------------------
// tb_cmos_capture
// Directed frames on an 8x4 sensor with SKIP_FRAMES = 2. Stimulus pushes the
// expected pixels and frame results into queues; monitors pop and compare
// whenever the DUT strobes pix_valid or frame_done. Also builds with
// CAPTURE_CROP_EN using a (2,1,4,2) window.
// -----------------------------------------------------------------------------
module tb_cmos_capture;

  localparam int SKIP = 2;
  localparam int H    = 8;
  localparam int V    = 4;
  localparam int CX0  = 2;
  localparam int CY0  = 1;
  localparam int CW   = 4;
  localparam int CH   = 2;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b0;
  logic        capture_en = 1'b0;
  logic        cmos_vsync = 1'b0;
  logic        cmos_href  = 1'b0;
  logic [7:0]  cmos_db    = 8'h00;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic [11:0] pix_x;
  logic [11:0] pix_y;
  logic        sof;
  logic        frame_done;
  logic        size_err;
  logic [15:0] frame_cnt;
  logic        busy;

  cmos_capture #(
    .SKIP_FRAMES (SKIP),
    .H_ACTIVE    (H),
    .V_ACTIVE    (V),
    .VSYNC_POL   (1),
    .CROP_X0     (CX0),
    .CROP_Y0     (CY0),
    .CROP_W      (CW),
    .CROP_H      (CH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .capture_en (capture_en),
    .cmos_vsync (cmos_vsync),
    .cmos_href  (cmos_href),
    .cmos_db    (cmos_db),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .sof        (sof),
    .frame_done (frame_done),
    .size_err   (size_err),
    .frame_cnt  (frame_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] data;
    logic [11:0] x;
    logic [11:0] y;
    logic        sof;
    bit          chk_lat;
    int          cyc;
  } px_t;

  typedef struct {
    logic        err;
    logic [15:0] cnt;
  } fr_t;

  px_t px_q[$];
  fr_t fr_q[$];
  px_t pe;
  fr_t fe;

  int errors    = 0;
  int checks    = 0;
  int fcnt_exp  = 0;
  bit first_exp = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pixel monitor: every strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && (pix_valid === 1'b1)) begin
      if (px_q.size() == 0) begin
        check("unexpected_pix_valid", 32'(pix_valid), 32'd0);
      end else begin
        pe = px_q.pop_front();
        check("pix_data", 32'(pix_data), 32'(pe.data));
        check("pix_x", 32'(pix_x), 32'(pe.x));
        check("pix_y", 32'(pix_y), 32'(pe.y));
        check("sof", 32'(sof), 32'(pe.sof));
        if (pe.chk_lat) check("pix_latency", 32'(cyc - pe.cyc), 32'd2);
      end
    end
  end

  // Frame monitor: every frame_done must match the head of the frame queue.
  always @(negedge clk) begin
    if (rst_n && (frame_done === 1'b1)) begin
      if (fr_q.size() == 0) begin
        check("unexpected_frame_done", 32'(frame_done), 32'd0);
      end else begin
        fe = fr_q.pop_front();
        check("size_err", 32'(size_err), 32'(fe.err));
        check("frame_cnt", 32'(frame_cnt), 32'(fe.cnt));
      end
    end
  end

  task automatic step(input logic vs, input logic hr, input logic [7:0] d);
    @(posedge clk);
    #1;
    cmos_vsync = vs;
    cmos_href  = hr;
    cmos_db    = d;
  endtask

  function automatic logic [7:0] hi_byte(input int y, input int p);
    return 8'((y << 4) | p);
  endfunction

  task automatic push_px(input logic [15:0] w, input int x, input int y, input bit lat);
    px_t e;
    bit  inw;
    int  ex;
    int  ey;
`ifdef CAPTURE_CROP_EN
    inw = (x >= CX0) && (x < CX0 + CW) && (y >= CY0) && (y < CY0 + CH);
    ex  = x - CX0;
    ey  = y - CY0;
`else
    inw = 1'b1;
    ex  = x;
    ey  = y;
`endif
    if (inw) begin
      e.data    = w;
      e.x       = 12'(ex);
      e.y       = 12'(ey);
      e.sof     = first_exp;
      e.chk_lat = lat;
      e.cyc     = cyc;
      first_exp = 1'b0;
      px_q.push_back(e);
    end
  endtask

  // One href line of nbytes bytes; pixel 0 of a special line is 0xF81F.
  task automatic send_line(input int y, input int nbytes, input bit cap, input bit special);
    for (int b = 0; b < nbytes; b++) begin
      int          p;
      logic [15:0] w;
      p = b / 2;
      if (special && (p == 0)) w = 16'hF81F;
      else w = {hi_byte(y, p), hi_byte(y, p) ^ 8'h5A};
      step(1'b0, 1'b1, (b % 2 == 0) ? w[15:8] : w[7:0]);
      if ((b % 2 == 1) && cap) push_px(w, p, y, special && (p == 0));
    end
    repeat (3) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_frame(input bit cap, input int short_line, input int odd_line,
                            input bit special, input int drop_at);
    for (int y = 0; y < V; y++) begin
      int nb;
      nb = 2 * H;
      if (y == short_line) nb = 2 * H - 2;
      else if (y == odd_line) nb = 2 * H + 1;
      if (y == drop_at) capture_en = 1'b0;
      send_line(y, nb, cap, special && (y == 0));
    end
  endtask

  // Frame boundary; optionally expects the frame it closes to be reported.
  task automatic vsync_pulse(input bit done, input bit err, input bit cap_next);
    fr_t f;
    if (done) begin
      fcnt_exp++;
      f.err = err;
      f.cnt = 16'(fcnt_exp);
      fr_q.push_back(f);
    end
    first_exp = cap_next;
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    repeat (3) step(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_pix_data", 32'(pix_data), 32'd0);
    check("rst_sof", 32'(sof), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_size_err", 32'(size_err), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    capture_en = 1'b1;
    rst_n      = 1'b1;
    repeat (2) step(1'b0, 1'b0, 8'h00);

    // Two settling frames, then a captured clean frame with 0xF81F first.
    vsync_pulse(1'b0, 1'b0, 1'b0); send_frame(1'b0, -1, -1, 1'b0, -1);
    check("busy_in_skip", 32'(busy), 32'd0);
    vsync_pulse(1'b0, 1'b0, 1'b0); send_frame(1'b0, -1, -1, 1'b0, -1);
    vsync_pulse(1'b0, 1'b0, 1'b1);
    check("busy_active", 32'(busy), 32'd1);
    send_frame(1'b1, -1, -1, 1'b1, -1);
    // Short line 2 (7 pixels).
    vsync_pulse(1'b1, 1'b0, 1'b1); send_frame(1'b1, 2, -1, 1'b0, -1);
    // Clean frame clears the error.
    vsync_pulse(1'b1, 1'b1, 1'b1); send_frame(1'b1, -1, -1, 1'b0, -1);
    // Odd 17-byte line 1.
    vsync_pulse(1'b1, 1'b0, 1'b1); send_frame(1'b1, -1, 1, 1'b0, -1);
    // Enable dropped before line 2: frame still completes.
    vsync_pulse(1'b1, 1'b1, 1'b1); send_frame(1'b1, -1, -1, 1'b0, 2);
    vsync_pulse(1'b1, 1'b0, 1'b0);
    check("busy_after_disable", 32'(busy), 32'd0);
    // Re-enable: two more skipped frames before capture resumes.
    capture_en = 1'b1;
    send_frame(1'b0, -1, -1, 1'b0, -1);
    vsync_pulse(1'b0, 1'b0, 1'b0); send_frame(1'b0, -1, -1, 1'b0, -1);
    vsync_pulse(1'b0, 1'b0, 1'b0); send_frame(1'b0, -1, -1, 1'b0, -1);
    vsync_pulse(1'b0, 1'b0, 1'b1); send_frame(1'b1, -1, -1, 1'b0, -1);
    vsync_pulse(1'b1, 1'b0, 1'b1);
    // Frame cut by vsync while href is high on line 3.
    for (int y = 0; y < V - 1; y++) send_line(y, 2 * H, 1'b1, 1'b0);
    for (int b = 0; b < 6; b++) begin
      logic [15:0] w;
      w = {hi_byte(3, b / 2), hi_byte(3, b / 2) ^ 8'h5A};
      step(1'b0, 1'b1, (b % 2 == 0) ? w[15:8] : w[7:0]);
      if (b % 2 == 1) push_px(w, b / 2, 3, 1'b0);
    end
    fcnt_exp++;
    fe.err = 1'b1;
    fe.cnt = 16'(fcnt_exp);
    fr_q.push_back(fe);
    step(1'b1, 1'b1, 8'hEE);
    step(1'b1, 1'b0, 8'h00);
    repeat (10) step(1'b0, 1'b0, 8'h00);

    check("pix_queue_drained", 32'(px_q.size()), 32'd0);
    check("frame_queue_drained", 32'(fr_q.size()), 32'd0);
    check("final_frame_cnt", 32'(frame_cnt), 32'd7);
    check("final_size_err_sticky", 32'(size_err), 32'd1);
    check("final_busy", 32'(busy), 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
